// File: rtl/gal22v10_bus_arbiter_pkg.sv
// arb_pkg: shared constants, state encoding and helpers for the GAL22V10 bus arbiter
package arb_pkg;
    localparam int ARB_N_REQ = 4;
    localparam int HOLD_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    function automatic logic [ARB_N_REQ-1:0] req_bit(input logic [1:0] idx);
        return ARB_N_REQ'(1) << idx;
    endfunction
endpackage

// File: rtl/gal22v10_bus_arbiter_rr_pick.sv
// rr_pick: round-robin winner search starting one past the last owner
module rr_pick
    import arb_pkg::*;
(
    input  logic [ARB_N_REQ-1:0] i_pend,
    input  logic [1:0]           i_last,
    output logic                 o_valid,
    output logic [1:0]           o_win
);
    // Walk from farthest to nearest so the nearest pending index is assigned last
    always_comb begin
        o_valid = |i_pend;
        o_win   = i_last;
        for (int k = ARB_N_REQ; k >= 1; k--)
            if (i_pend[i_last + 2'(k)]) o_win = i_last + 2'(k);
    end
endmodule

// File: rtl/gal22v10_bus_arbiter.sv
// gal22v10_bus_arbiter: pin-level GAL22V10 round-robin arbiter for four backplane requesters
module gal22v10_bus_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD    = 16,
    parameter int TURN_CYCLES = 1
) (
    input  logic port1,
    input  logic port2,
    input  logic port3,
    input  logic port4,
    input  logic port5,
    input  logic port6,
    input  logic port7,
    input  logic port8,
    input  logic port9,
    input  logic port10,
    input  logic port11,
    input  logic port12,
    input  logic port13,
    output logic port14,
    output logic port15,
    output logic port16,
    output logic port17,
    output logic port18,
    output logic port19,
    output logic port20,
    output logic port21,
    output logic port22,
    output logic port23,
    input  logic port24
);
    arb_state_e           r_state;
    logic [3:0]           r_gnt_n;
    logic [1:0]           r_owner;
    logic [1:0]           r_last;
    logic [1:0]           r_turn;
    logic [HOLD_W-1:0]    r_hold;
    logic                 r_busy_n;
    logic                 r_tout_n;
    logic [ARB_N_REQ-1:0] w_pend;
    logic                 w_valid;
    logic [1:0]           w_win;
    logic                 w_inc;
    logic                 w_rel;
    logic                 w_tmo;
    logic                 w_arb;
    logic                 w_unused;

    assign w_pend   = ~{port6, port5, port4, port3};
    assign w_inc    = |(w_pend & ~req_bit(r_owner)) & port7;
    assign w_rel    = ~w_pend[r_owner];
    assign w_tmo    = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD - 1)) && w_inc;
    // Arbitration happens in IDLE and on the final turnaround cycle
    assign w_arb    = (r_state != TURN) || (r_turn <= 2'd1);
    assign w_unused = ^{port8, port9, port10, port11, port12, port13, port24};

    rr_pick u_pick (
        .i_pend  (w_pend),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_win   (w_win)
    );

    always_ff @(posedge port1 or negedge port2) begin
        if (!port2) begin
            r_state  <= IDLE;
            r_gnt_n  <= '1;
            r_owner  <= '0;
            r_last   <= 2'd3;
            r_turn   <= '0;
            r_hold   <= '0;
            r_busy_n <= 1'b1;
            r_tout_n <= 1'b1;
        end else begin
            r_tout_n <= 1'b1;
            if (r_state == GRANT) begin
                if (w_rel || w_tmo) begin
                    r_gnt_n  <= '1;
                    r_busy_n <= 1'b1;
                    r_state  <= TURN;
                    r_turn   <= 2'(TURN_CYCLES);
                    r_hold   <= '0;
                    r_tout_n <= w_rel;
                end else
                    r_hold <= w_inc ? r_hold + HOLD_W'(r_hold != '1) : '0;
            end else if (!w_arb)
                r_turn <= r_turn - 2'd1;
            else if (w_valid) begin
                r_gnt_n  <= ~req_bit(w_win);
                r_owner  <= w_win;
                r_last   <= w_win;
                r_busy_n <= 1'b0;
                r_state  <= GRANT;
            end else
                r_state <= IDLE;
        end
    end

    assign {port17, port16, port15, port14} = r_gnt_n;
    assign {port19, port18}                 = r_owner;
    assign port20                           = r_busy_n;
    assign port21                           = r_tout_n;
    assign port22                           = 1'b1;
    assign port23                           = 1'b1;
endmodule

// File: tb/tb_gal22v10_bus_arbiter.sv
// tb_gal22v10_bus_arbiter: directed and random checks of two arbiter configurations against a cycle model
module tb_gal22v10_bus_arbiter;
    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] req_n  = 4'hF;
    logic       lock_n = 1'b1;
    logic [3:0] a_gnt, b_gnt;
    logic [1:0] a_own, b_own;
    logic       a_busy, b_busy, a_tout, b_tout, a_p22, a_p23, b_p22, b_p23;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         n;

    // Model: owner (-1 = bus free), idle cycles left, last grantee, shown owner, hold count
    int   m_own[2], m_gap[2], m_last[2], m_show[2], m_wait[2];
    logic m_tout[2];
    int   mh[2] = '{16, 4};
    int   tc[2] = '{1, 3};

    always #5 clk = ~clk;

    gal22v10_bus_arbiter u_a (
        .port1(clk), .port2(rst_n), .port3(req_n[0]), .port4(req_n[1]), .port5(req_n[2]),
        .port6(req_n[3]), .port7(lock_n), .port8(1'b1), .port9(1'b1), .port10(1'b1),
        .port11(1'b1), .port12(1'b0), .port13(1'b1), .port14(a_gnt[0]), .port15(a_gnt[1]),
        .port16(a_gnt[2]), .port17(a_gnt[3]), .port18(a_own[0]), .port19(a_own[1]),
        .port20(a_busy), .port21(a_tout), .port22(a_p22), .port23(a_p23), .port24(1'b1)
    );

    gal22v10_bus_arbiter #(.MAX_HOLD(4), .TURN_CYCLES(3)) u_b (
        .port1(clk), .port2(rst_n), .port3(req_n[0]), .port4(req_n[1]), .port5(req_n[2]),
        .port6(req_n[3]), .port7(lock_n), .port8(1'b1), .port9(1'b1), .port10(1'b1),
        .port11(1'b1), .port12(1'b0), .port13(1'b1), .port14(b_gnt[0]), .port15(b_gnt[1]),
        .port16(b_gnt[2]), .port17(b_gnt[3]), .port18(b_own[0]), .port19(b_own[1]),
        .port20(b_busy), .port21(b_tout), .port22(b_p22), .port23(b_p23), .port24(1'b1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1; m_gap[i] = 0; m_last[i] = 3; m_show[i] = 0; m_wait[i] = 0; m_tout[i] = 1'b1;
        end
    endfunction

    function automatic void m_step(input int i);
        logic [3:0] p;
        bit others, found;
        int j;
        p = ~req_n;
        m_tout[i] = 1'b1;
        if (m_own[i] >= 0) begin
            others = 0;
            for (int k = 0; k < 4; k++) if (k != m_own[i] && p[k]) others = 1;
            if (!p[m_own[i]]) begin
                m_own[i] = -1; m_gap[i] = tc[i];
            end else if (others && lock_n) begin
                if (mh[i] != 0 && m_wait[i] == mh[i] - 1) begin
                    m_own[i] = -1; m_gap[i] = tc[i]; m_tout[i] = 1'b0;
                end else m_wait[i] = (m_wait[i] < 255) ? m_wait[i] + 1 : 255;
            end else m_wait[i] = 0;
        end else if (m_gap[i] > 1) m_gap[i]--;
        else begin
            m_gap[i] = 0;
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                j = (m_last[i] + k) % 4;
                if (!found && p[j]) begin
                    found = 1; m_own[i] = j; m_last[i] = j; m_show[i] = j; m_wait[i] = 0;
                end
            end
        end
    endfunction

    function automatic logic [3:0] eg(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return (m_own[i] < 0) ? 4'hF : ~(one << m_own[i]);
    endfunction

    task automatic check_all();
        chk("a_gnt", 8'(a_gnt), 8'(eg(0)));
        chk("a_owner", 8'(a_own), 8'(m_show[0]));
        chk("a_busy", 8'(a_busy), 8'(m_own[0] < 0));
        chk("a_tout", 8'(a_tout), 8'(m_tout[0]));
        chk("b_gnt", 8'(b_gnt), 8'(eg(1)));
        chk("b_owner", 8'(b_own), 8'(m_show[1]));
        chk("b_busy", 8'(b_busy), 8'(m_own[1] < 0));
        chk("b_tout", 8'(b_tout), 8'(m_tout[1]));
        chk("a_single_grant", 8'($countones(~a_gnt) > 1), 8'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst_n) m_reset();
        else begin
            m_step(0);
            m_step(1);
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        req_n  = 4'hF;
        lock_n = 1'b1;
        rst_n  = 1'b0;
        #1;
        m_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int sel, output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while ((sel != 0 ? b_busy : a_busy) && cnt < 40);
        chk("wait_grant", 8'(sel != 0 ? b_busy : a_busy), 8'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values and first grant
        do_reset();
        chk("rst_gnt", 8'(a_gnt), 8'hF);
        chk("rst_owner", 8'(a_own), 8'd0);
        chk("rst_busy", 8'(a_busy), 8'd1);
        chk("rst_tout", 8'(a_tout), 8'd1);
        chk("unused_out", 8'({a_p22, a_p23, b_p22, b_p23}), 8'hF);
        req_n = 4'b1110;
        cyc();
        chk("first_gnt", 8'(a_gnt), 8'hE);
        chk("first_owner", 8'(a_own), 8'd0);
        chk("first_busy", 8'(a_busy), 8'd0);
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", 8'(a_gnt), 8'hF);
        chk("async_rst_busy", 8'(b_busy), 8'd1);
        m_reset();
        cyc();
        rst_n = 1'b1;

        // Round robin, each owner releasing after three grant cycles
        do_reset();
        req_n = 4'h0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(0, n);
            chk("rr_owner", 8'(a_own), 8'(k % 4));
            chk("rr_idle", 8'(n), 8'd1);
            cyc();
            cyc();
            req_n[a_own] = 1'b1;
            cyc();
            req_n = 4'h0;
        end

        // Three-cycle turnaround on the second instance
        do_reset();
        req_n = 4'b1101;
        wait_grant(1, n);
        chk("tc3_gnt1", 8'(b_gnt), 8'hD);
        req_n = 4'b1011;
        cyc();
        chk("tc3_release", 8'(b_gnt), 8'hF);
        wait_grant(1, n);
        chk("tc3_idle", 8'(n), 8'd3);
        chk("tc3_gnt2", 8'(b_gnt), 8'hB);

        // Forced release after MAX_HOLD cycles
        do_reset();
        req_n = 4'b1110;
        cyc();
        req_n = 4'b1100;
        n = 1;
        for (int k = 0; k < 40 && !a_gnt[0]; k++) begin
            cyc();
            if (!a_gnt[0]) n++;
        end
        chk("tmo_hold_len", 8'(n), 8'd16);
        chk("tmo_pulse", 8'(a_tout), 8'd0);
        cyc();
        chk("tmo_pulse_end", 8'(a_tout), 8'd1);
        chk("tmo_next_gnt", 8'(a_gnt), 8'hD);

        // LOCK_N suspends and then restarts the hold count
        do_reset();
        req_n = 4'b1110;
        cyc();
        lock_n = 1'b0;
        req_n  = 4'b1100;
        repeat (40) cyc();
        chk("lock_held", 8'(a_gnt), 8'hE);
        lock_n = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!a_gnt[0] && n < 40);
        chk("lock_restart_len", 8'(n), 8'd16);
        chk("lock_tmo_pulse", 8'(a_tout), 8'd0);

        // Owner release coinciding with timeout is a normal release
        do_reset();
        req_n = 4'b1011;
        cyc();
        chk("coll_owner", 8'(a_own), 8'd2);
        req_n = 4'b1010;
        repeat (15) cyc();
        chk("coll_still_gnt", 8'(a_gnt), 8'hB);
        req_n = 4'b1110;
        cyc();
        chk("coll_release", 8'(a_gnt), 8'hF);
        chk("coll_no_pulse", 8'(a_tout), 8'd1);
        req_n = 4'b1011;
        cyc();
        chk("coll_regrant", 8'(a_gnt), 8'hB);

        // Random traffic against the model
        do_reset();
        repeat (800) begin
            for (int j = 0; j < 4; j++) if ($urandom_range(7) == 0) req_n[j] = ~req_n[j];
            if ($urandom_range(15) == 0) lock_n = ~lock_n;
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
